// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, muldiv op encoding and sequencer states
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;

  typedef enum logic [2:0] {
    MD_MUL  = 3'b000,
    MD_DIV  = 3'b100,
    MD_DIVU = 3'b101,
    MD_REM  = 3'b110,
    MD_REMU = 3'b111
  } md_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - RV32M mul/div sequencer driving the shared ALU lanes
// Signed DIV/REM (PREP/FIX states) present only when MULDIV_SIGNED_EN is defined.
module alu_muldiv_seq
  import alu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_op_i,
  input  logic [XLEN-1:0] req_a_i,
  input  logic [XLEN-1:0] req_b_i,
  input  logic            flush_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_data_o,
  output logic            rsp_illegal_o,
  output logic            busy_o,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  output logic [3:0]      alu_op_o,
  input  logic [XLEN-1:0] alu_c_i
);

  seq_state_e      state_q, state_d;
  logic [4:0]      cnt_q;
  logic [2:0]      op_q;
  logic            illegal_q;
  // a_q: multiplicand / dividend then quotient; b_q: multiplier / divisor; acc_q: product / remainder
  logic [XLEN-1:0] a_q, b_q, acc_q;
  logic [XLEN-1:0] r_sh;
  logic            borrow, accept, op_mul, req_legal, req_signed;

  assign accept     = (state_q == S_IDLE) & req_valid_i & ~flush_i;
  assign op_mul     = (op_q == MD_MUL);
  assign req_signed = (req_op_i == MD_DIV) | (req_op_i == MD_REM);
  assign req_legal  = (req_op_i == MD_MUL) | (req_op_i == MD_DIVU) | (req_op_i == MD_REMU)
`ifdef MULDIV_SIGNED_EN
                    | req_signed
`endif
                    ;

  // r_sh is 33 bits wide in truth; acc_q[31] is the dropped MSB, which forbids a borrow
  assign r_sh   = {acc_q[XLEN-2:0], a_q[XLEN-1]};
  assign borrow = ~acc_q[XLEN-1] & ((~r_sh[XLEN-1] & b_q[XLEN-1]) |
                  (~(r_sh[XLEN-1] ^ b_q[XLEN-1]) & alu_c_i[XLEN-1]));

`ifdef MULDIV_SIGNED_EN
  logic sgn_a_q, sgn_b_q, b_zero_q, op_signed;
  assign op_signed = (op_q == MD_DIV) | (op_q == MD_REM);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    alu_a_o  = '0;
    alu_b_o  = '0;
    alu_op_o = ALU_ADD;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          if (!req_legal)      state_d = S_DONE;
`ifdef MULDIV_SIGNED_EN
          else if (req_signed) state_d = S_PREP;
`endif
          else                 state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (op_mul) begin
          alu_a_o = acc_q;
          alu_b_o = a_q;
        end else begin
          alu_a_o  = r_sh;
          alu_b_o  = b_q;
          alu_op_o = ALU_SUB;
        end
        if (cnt_q == 5'd31) begin
`ifdef MULDIV_SIGNED_EN
          state_d = op_signed ? S_FIX : S_DONE;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef MULDIV_SIGNED_EN
      S_PREP: begin
        alu_b_o  = cnt_q[0] ? b_q : a_q;
        alu_op_o = ALU_SUB;
        if (cnt_q[0]) state_d = S_RUN;
      end
      S_FIX: begin
        alu_b_o  = cnt_q[0] ? acc_q : a_q;
        alu_op_o = ALU_SUB;
        if (cnt_q[0]) state_d = S_DONE;
      end
`endif
      S_DONE: if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      op_q      <= '0;
      illegal_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
`ifdef MULDIV_SIGNED_EN
      sgn_a_q   <= 1'b0;
      sgn_b_q   <= 1'b0;
      b_zero_q  <= 1'b0;
`endif
    end else begin
      cnt_q <= (state_d != state_q) ? 5'd0 : cnt_q + 5'd1;
      case (state_q)
        S_IDLE: if (accept) begin
          op_q      <= req_op_i;
          illegal_q <= ~req_legal;
          a_q       <= req_a_i;
          b_q       <= req_b_i;
          acc_q     <= '0;
`ifdef MULDIV_SIGNED_EN
          sgn_a_q   <= req_a_i[XLEN-1];
          sgn_b_q   <= req_b_i[XLEN-1];
          b_zero_q  <= (req_b_i == '0);
`endif
        end
        S_RUN: begin
          if (op_mul) begin
            if (b_q[0]) acc_q <= alu_c_i;
            a_q <= a_q << 1;
            b_q <= b_q >> 1;
          end else begin
            acc_q <= borrow ? r_sh : alu_c_i;
            a_q   <= {a_q[XLEN-2:0], ~borrow};
          end
        end
`ifdef MULDIV_SIGNED_EN
        S_PREP: begin
          if (!cnt_q[0] && a_q[XLEN-1]) a_q <= alu_c_i;
          if (cnt_q[0] && b_q[XLEN-1])  b_q <= alu_c_i;
        end
        S_FIX: begin
          if (!cnt_q[0] && (sgn_a_q ^ sgn_b_q) && !b_zero_q) a_q <= alu_c_i;
          if (cnt_q[0] && sgn_a_q) acc_q <= alu_c_i;
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    rsp_data_o = '0;
    if (state_q == S_DONE && !illegal_q) begin
      if (op_mul || op_q[1]) rsp_data_o = acc_q;
      else                   rsp_data_o = a_q;
    end
  end

  assign req_ready_o   = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign rsp_valid_o   = (state_q == S_DONE);
  assign rsp_illegal_o = (state_q == S_DONE) & illegal_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - directed self-checking bench for alu_muldiv_seq
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        flush = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_illegal;
  logic        busy;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [3:0]  alu_op;

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  int exp_hs = 0;

  always #5 clk = ~clk;

  // Execute-stage ALU stand-in: only ADD and SUB are exercised by the sequencer
  assign alu_c = (alu_op == 4'b0110) ? alu_a - alu_b : alu_a + alu_b;

  alu_muldiv_seq dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_a_i(req_a), .req_b_i(req_b), .flush_i(flush),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_illegal_o(rsp_illegal), .busy_o(busy),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_c_i(alu_c)
  );

  always @(posedge clk) if (rst_n && rsp_valid && rsp_ready) hs_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a posedge with the sequencer idle; returns #1 after a posedge
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_data,
                        input int exp_lat, input logic exp_ill, input logic consume);
    int lat;
    chk({tag, " ready"}, {31'd0, req_ready}, 32'd1);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " data"}, rsp_data, exp_data);
    chk({tag, " illegal"}, {31'd0, rsp_illegal}, {31'd0, exp_ill});
    if (consume) begin
      @(posedge clk); #1;
      exp_hs++;
      chk({tag, " back idle"}, {30'd0, req_ready, rsp_valid}, 32'b10);
    end
  endtask

  initial begin
    #1;
    chk("reset ready", {31'd0, req_ready}, 32'd1);
    chk("reset valid/busy/ill", {29'd0, rsp_valid, busy, rsp_illegal}, 32'd0);
    chk("reset data", rsp_data, 32'd0);
    chk("reset alu lanes", alu_a | alu_b, 32'd0);
    chk("reset alu op", {28'd0, alu_op}, 32'h2);
    #13 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul 7x6", 3'b000, 32'd7, 32'd6, 32'd42, 33, 1'b0, 1'b1);
    run_op("mul ffff", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 33, 1'b0, 1'b1);
    run_op("divu 100/7", 3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b0, 1'b1);
    run_op("remu 100/7", 3'b111, 32'd100, 32'd7, 32'd2, 33, 1'b0, 1'b1);
    run_op("divu ffff/1", 3'b101, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33, 1'b0, 1'b1);
    run_op("divu 5/0", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 33, 1'b0, 1'b1);
    run_op("remu 5/0", 3'b111, 32'd5, 32'd0, 32'd5, 33, 1'b0, 1'b1);

`ifdef MULDIV_SIGNED_EN
    run_op("div -7/2", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 37, 1'b0, 1'b1);
    run_op("rem -7/2", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 37, 1'b0, 1'b1);
    run_op("div ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 37, 1'b0, 1'b1);
    run_op("rem ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 37, 1'b0, 1'b1);
`else
    run_op("div illegal", 3'b100, 32'hFFFFFFF9, 32'd2, 32'h0, 1, 1'b1, 1'b1);
    run_op("rem illegal", 3'b110, 32'hFFFFFFF9, 32'd2, 32'h0, 1, 1'b1, 1'b1);
`endif

    // Flush in RUN step 10, then a MUL whose response is stalled for 5 cycles
    req_op = 3'b000; req_a = 32'd5; req_b = 32'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("pre-flush busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush idle", {29'd0, busy, rsp_valid, req_ready}, 32'b001);
    chk("flush alu op", {28'd0, alu_op}, 32'h2);
    rsp_ready = 1'b0;
    run_op("mul 3x3", 3'b000, 32'd3, 32'd3, 32'd9, 33, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stall %0d", i), {rsp_valid, rsp_data[30:0]}, {1'b1, 31'd9});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    exp_hs++;
    chk("stall released", {31'd0, rsp_valid}, 32'd0);
    chk("handshake count", 32'(hs_cnt), 32'(exp_hs));

    // Asynchronous reset mid-operation
    run_op("mul pre-reset", 3'b000, 32'd11, 32'd13, 32'd143, 33, 1'b0, 1'b1);
    req_op = 3'b101; req_a = 32'd1000; req_b = 32'd3; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("async reset busy", {30'd0, busy, rsp_valid}, 32'd0);
    chk("async reset ready", {31'd0, req_ready}, 32'd1);
    chk("async reset lanes", alu_a | alu_b, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("divu after reset", 3'b101, 32'd1000, 32'd3, 32'd333, 33, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
